acond_sensores: RTL

- Input-conditioning stage directly upstream of the temperature/alarm top level.
- Samples the raw temperature bus and debounces the motion, presence and enable pushbutton inputs.
- Produces clean, stable versions of t, m, p and EN that feed the BCD converter, temperature decoder and main state machine.
- Runs on the board clock ahead of the frequency divider, with an internal sample tick.

---
 rtl/acond_sensores_if.sv | 25 ++
 rtl/acond_sensores.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/acond_sensores_if.sv
// rtl/acond_sensores_if.sv - raw sensor inputs and conditioned outputs of acond_sensores
interface acond_sensores_if;
  logic [5:0] t_raw;
  logic       m_raw;
  logic       p_raw;
  logic       en_btn;
  logic [5:0] t;
  logic       m;
  logic       p;
  logic       EN;
  logic       t_vld;
  logic       upd;

  // Sensor side: drives raw levels, observes conditioned values
  modport master (
    output t_raw, m_raw, p_raw, en_btn,
    input  t, m, p, EN, t_vld, upd
  );

  // Conditioning block side
  modport slave (
    input  t_raw, m_raw, p_raw, en_btn,
    output t, m, p, EN, t_vld, upd
  );
endinterface

// File: rtl/acond_sensores.sv
// rtl/acond_sensores.sv - sample tick, debounce of m/p/EN, temperature sampling (ACOND_TEMP_AVG_EN: 4-sample average)
module acond_sensores #(
  parameter int SAMPLE_DIV = 50000,
  parameter int DB_CYCLES  = 4
) (
  input logic         clk,
  input logic         rst,
  acond_sensores_if.slave bus
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  // Channel order: 0 = motion, 1 = presence, 2 = enable button
  logic [2:0] w_raw;
  logic [2:0] r_s;
  logic [3:0] r_c [3];
  logic [2:0] w_fire;

  logic       r_en;
  logic [5:0] r_t;
  logic       r_t_vld;
  logic       r_upd;

  assign w_tick = (r_cnt == TICK_LAST);
  assign w_raw  = {bus.en_btn, bus.p_raw, bus.m_raw};

  // Free-running sample tick counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A channel flips its stable level when this tick completes the persistence count
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < 3; i++) begin
      w_fire[i] = w_tick && (w_raw[i] != r_s[i]) && (r_c[i] == DB_LAST);
    end
  end

  // Debounce counters and stable levels, updated only on tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s <= '0;
      for (int i = 0; i < 3; i++) begin
        r_c[i] <= '0;
      end
    end else if (w_tick) begin
      for (int i = 0; i < 3; i++) begin
        if (w_raw[i] == r_s[i]) begin
          r_c[i] <= '0;
        end else if (r_c[i] == DB_LAST) begin
          r_s[i] <= w_raw[i];
          r_c[i] <= '0;
        end else begin
          r_c[i] <= r_c[i] + 1'b1;
        end
      end
    end
  end

  // EN toggles on each debounced press; release has no effect
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en <= 1'b0;
    end else if (w_fire[2] && w_raw[2]) begin
      r_en <= ~r_en;
    end
  end

`ifdef ACOND_TEMP_AVG_EN
  logic [5:0] r_w [4];
  logic [2:0] r_f;
  logic [2:0] w_f_next;
  logic [7:0] w_sum;
  logic [5:0] w_avg;

  // The average covers the window as it will be after this tick's shift
  assign w_f_next = (r_f == 3'd4) ? 3'd4 : r_f + 3'd1;
  assign w_sum    = {2'b00, bus.t_raw} + {2'b00, r_w[0]} + {2'b00, r_w[1]} + {2'b00, r_w[2]};
  assign w_avg    = 6'(w_sum >> 2);

  // Sample window, fill count and averaged temperature output
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        r_w[i] <= '0;
      end
      r_f     <= '0;
      r_t     <= '0;
      r_t_vld <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_tick) begin
        r_w[0] <= bus.t_raw;
        r_w[1] <= r_w[0];
        r_w[2] <= r_w[1];
        r_w[3] <= r_w[2];
        r_f    <= w_f_next;
        if (w_f_next == 3'd4) begin
          r_t     <= w_avg;
          r_t_vld <= 1'b1;
          r_upd   <= 1'b1;
        end
      end
    end
  end
`else
  // Direct sampling of the temperature bus on every tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_t     <= '0;
      r_t_vld <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_tick) begin
        r_t     <= bus.t_raw;
        r_t_vld <= 1'b1;
        r_upd   <= 1'b1;
      end
    end
  end
`endif

  assign bus.t     = r_t;
  assign bus.m     = r_s[0];
  assign bus.p     = r_s[1];
  assign bus.EN    = r_en;
  assign bus.t_vld = r_t_vld;
  assign bus.upd   = r_upd;

endmodule
